// File: rtl/serial_adder_if.sv
// Request/result bundle for the bit-serial adder.
// The master drives operands and start; the slave returns status and result.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Sum;
    logic             Cout;

    modport master (
        output start, A, B, Cin,
        input  busy, done, Sum, Cout
    );

    modport slave (
        input  start, A, B, Cin,
        output busy, done, Sum, Cout
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder slice built from two half adders,
// processing LSB first with a registered carry between cycles.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input logic           clk,
    input logic           rst,
    serial_adder_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sum_nxt;
    logic [WIDTH-1:0] sum_q;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             cout_q;
    logic             load;
    logic             last;
    logic [1:0]       ha0;
    logic [1:0]       ha1;
    logic             s;
    logic             c;

    // {carry, sum} of a single half-adder cell
    function automatic logic [1:0] ha(input logic a, input logic b);
        return {a & b, a ^ b};
    endfunction

    assign ha0  = ha(sa[0], sb[0]);
    assign ha1  = ha(ha0[0], carry);
    assign s    = ha1[0];
    assign c    = ha0[1] | ha1[1];
    assign last = (cnt == CNT_W'(WIDTH - 1));

    // The new bit enters at the MSB so the word is aligned after WIDTH shifts
    if (WIDTH == 1) begin : g_w1
        assign sum_nxt = s;
    end else begin : g_wn
        assign sum_nxt = {s, sreg[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sa     <= '0;
            sb     <= '0;
            sreg   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (load) begin
            sa    <= bus.A;
            sb    <= bus.B;
            carry <= bus.Cin;
            sreg  <= '0;
            cnt   <= '0;
        end else if (state == RUN) begin
            sa    <= sa >> 1;
            sb    <= sb >> 1;
            carry <= c;
            sreg  <= sum_nxt;
            cnt   <= cnt + CNT_W'(1);
            if (last) begin
                sum_q  <= sum_nxt;
                cout_q <= c;
            end
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.Sum  = sum_q;
    assign bus.Cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at WIDTH 8, 1 and 32.
// Stimulus is driven and outputs sampled on the falling clock edge.
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8))  i8 ();
    serial_adder_if #(.WIDTH(1))  i1 ();
    serial_adder_if #(.WIDTH(32)) i32 ();

    serial_adder #(.WIDTH(8)) u8 (
        .clk(clk),
        .rst(rst),
        .bus(i8)
    );
    serial_adder #(.WIDTH(1)) u1 (
        .clk(clk),
        .rst(rst),
        .bus(i1)
    );
    serial_adder #(.WIDTH(32)) u32 (
        .clk(clk),
        .rst(rst),
        .bus(i32)
    );

    // One WIDTH=8 operation; scrambles operands after the accepting edge.
    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        input logic cin, output int lat,
                        output int nbusy, output int ndone);
        lat   = -1;
        nbusy = 0;
        ndone = 0;
        @(negedge clk);
        i8.A     = a;
        i8.B     = b;
        i8.Cin   = cin;
        i8.start = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (n == 1) begin
                i8.start = 1'b0;
                i8.A     = ~a;
                i8.B     = ~b;
                i8.Cin   = ~cin;
            end
            if (i8.busy) nbusy++;
            if (i8.done) begin
                ndone++;
                if (lat < 0) lat = n;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({i8.busy, i8.done, i8.Sum, i8.Cout} !== 11'h0) begin
            errors++;
            $display("FAIL reset8 got busy=%b done=%b sum=%h cout=%b want 0",
                     i8.busy, i8.done, i8.Sum, i8.Cout);
        end
        checks++;
        if ({i32.busy, i32.done, i32.Sum, i32.Cout} !== 35'h0) begin
            errors++;
            $display("FAIL reset32 got busy=%b done=%b sum=%h cout=%b want 0",
                     i32.busy, i32.done, i32.Sum, i32.Cout);
        end
    endtask

    task automatic test_zero();
        int lat, nb, nd;
        run8(8'h00, 8'h00, 1'b0, lat, nb, nd);
        checks++;
        if (nb !== 8) begin
            errors++;
            $display("FAIL zero_busy got %0d want 8", nb);
        end
        checks++;
        if (lat !== 9 || nd !== 1) begin
            errors++;
            $display("FAIL zero_done got lat=%0d n=%0d want 9 1", lat, nd);
        end
        checks++;
        if ({i8.Cout, i8.Sum} !== 9'h000) begin
            errors++;
            $display("FAIL zero_sum got %h want 000", {i8.Cout, i8.Sum});
        end
    endtask

    task automatic test_carry();
        logic [7:0] ta [3] = '{8'hFF, 8'hA5, 8'h3C};
        logic [7:0] tb [3] = '{8'h01, 8'h5A, 8'h42};
        logic       tc [3] = '{1'b0, 1'b1, 1'b0};
        logic [8:0] te [3] = '{9'h100, 9'h100, 9'h07E};
        int lat, nb, nd;
        for (int i = 0; i < 3; i++) begin
            run8(ta[i], tb[i], tc[i], lat, nb, nd);
            checks++;
            if ({i8.Cout, i8.Sum} !== te[i] || lat !== 9) begin
                errors++;
                $display("FAIL carry%0d got %h lat=%0d want %h lat=9",
                         i, {i8.Cout, i8.Sum}, lat, te[i]);
            end
        end
    endtask

    task automatic test_busy_guard();
        int lat = -1;
        int nd = 0;
        @(negedge clk);
        i8.A     = 8'h12;
        i8.B     = 8'h34;
        i8.Cin   = 1'b0;
        i8.start = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (n == 1) i8.start = 1'b0;
            if (n == 3) begin
                i8.start = 1'b1;
                i8.A     = 8'h11;
                i8.B     = 8'h11;
            end
            if (n == 4) i8.start = 1'b0;
            if (i8.done) begin
                nd++;
                if (lat < 0) lat = n;
            end
        end
        checks++;
        if (nd !== 1 || lat !== 9) begin
            errors++;
            $display("FAIL guard_done got n=%0d lat=%0d want 1 9", nd, lat);
        end
        checks++;
        if ({i8.Cout, i8.Sum} !== 9'h046) begin
            errors++;
            $display("FAIL guard_sum got %h want 046", {i8.Cout, i8.Sum});
        end
    endtask

    task automatic test_back_to_back();
        int         t [2] = '{-1, -1};
        logic [8:0] r [2] = '{9'h1FF, 9'h1FF};
        int         nd = 0;
        @(negedge clk);
        i8.A     = 8'h3C;
        i8.B     = 8'h42;
        i8.Cin   = 1'b0;
        i8.start = 1'b1;
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            i8.start = 1'b0;
            if (i8.done) begin
                if (nd < 2) begin
                    t[nd] = n;
                    r[nd] = {i8.Cout, i8.Sum};
                end
                if (nd == 0) begin
                    i8.A     = 8'h0F;
                    i8.B     = 8'h01;
                    i8.start = 1'b1;
                end
                nd++;
            end
        end
        checks++;
        if (t[0] !== 9 || r[0] !== 9'h07E) begin
            errors++;
            $display("FAIL b2b_first got t=%0d sum=%h want 9 07e", t[0], r[0]);
        end
        checks++;
        if (t[1] !== 18 || r[1] !== 9'h010 || nd !== 2) begin
            errors++;
            $display("FAIL b2b_second got t=%0d sum=%h n=%0d want 18 010 2",
                     t[1], r[1], nd);
        end
    endtask

    task automatic test_reset_midop();
        int lat, nb, nd;
        int ndm = 0;
        logic [10:0] st = '1;
        run8(8'h3C, 8'h42, 1'b0, lat, nb, nd);
        checks++;
        if ({i8.Cout, i8.Sum} !== 9'h07E) begin
            errors++;
            $display("FAIL midop_prior got %h want 07e", {i8.Cout, i8.Sum});
        end
        @(negedge clk);
        i8.A     = 8'h0F;
        i8.B     = 8'h01;
        i8.Cin   = 1'b0;
        i8.start = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (n == 1) i8.start = 1'b0;
            if (n == 4) rst = 1'b1;
            if (n == 5) begin
                rst = 1'b0;
                st  = {i8.busy, i8.done, i8.Sum, i8.Cout};
            end
            if (i8.done) ndm++;
        end
        checks++;
        if (st !== 11'h0) begin
            errors++;
            $display("FAIL midop_state got %h want 000", st);
        end
        checks++;
        if (ndm !== 0) begin
            errors++;
            $display("FAIL midop_done got %0d pulses want 0", ndm);
        end
        run8(8'h0F, 8'h01, 1'b0, lat, nb, nd);
        checks++;
        if ({i8.Cout, i8.Sum} !== 9'h010 || lat !== 9) begin
            errors++;
            $display("FAIL midop_fresh got %h lat=%0d want 010 9",
                     {i8.Cout, i8.Sum}, lat);
        end
    endtask

    task automatic test_width1();
        logic a, b, c;
        logic [1:0] exp;
        int lat;
        for (int v = 0; v < 8; v++) begin
            a   = v[2];
            b   = v[1];
            c   = v[0];
            exp = 2'(a) + 2'(b) + 2'(c);
            lat = -1;
            @(negedge clk);
            i1.A     = a;
            i1.B     = b;
            i1.Cin   = c;
            i1.start = 1'b1;
            for (int n = 1; n <= 5; n++) begin
                @(negedge clk);
                i1.start = 1'b0;
                if (i1.done && lat < 0) begin
                    lat = n;
                    checks++;
                    if ({i1.Cout, i1.Sum} !== exp) begin
                        errors++;
                        $display("FAIL w1_%0d got %b want %b",
                                 v, {i1.Cout, i1.Sum}, exp);
                    end
                end
            end
            checks++;
            if (lat !== 2) begin
                errors++;
                $display("FAIL w1_lat%0d got %0d want 2", v, lat);
            end
        end
    endtask

    task automatic test_random8();
        logic [7:0] a, b, ps;
        logic       cin, pc;
        logic [8:0] exp;
        logic       hold_bad = 1'b0;
        int         lat;
        for (int k = 0; k < 1000; k++) begin
            a   = 8'($urandom);
            b   = 8'($urandom);
            cin = 1'($urandom);
            exp = 9'(a) + 9'(b) + 9'(cin);
            ps  = i8.Sum;
            pc  = i8.Cout;
            lat = -1;
            @(negedge clk);
            i8.A     = a;
            i8.B     = b;
            i8.Cin   = cin;
            i8.start = 1'b1;
            for (int n = 1; n <= 12; n++) begin
                @(negedge clk);
                i8.start = 1'b0;
                if (i8.done) begin
                    lat = n;
                    break;
                end
                if (i8.Sum !== ps || i8.Cout !== pc) hold_bad = 1'b1;
            end
            checks++;
            if ({i8.Cout, i8.Sum} !== exp || lat !== 9) begin
                errors++;
                $display("FAIL rand8_%0d %h+%h+%b got %h lat=%0d want %h lat=9",
                         k, a, b, cin, {i8.Cout, i8.Sum}, lat, exp);
            end
        end
        checks++;
        if (hold_bad !== 1'b0) begin
            errors++;
            $display("FAIL rand8_hold got unstable=%b want 0", hold_bad);
        end
    endtask

    task automatic test_random32();
        logic [31:0] a, b, ps;
        logic        cin, pc;
        logic [32:0] exp;
        logic        hold_bad = 1'b0;
        int          lat;
        for (int k = 0; k < 1000; k++) begin
            a   = $urandom;
            b   = $urandom;
            cin = 1'($urandom);
            exp = 33'(a) + 33'(b) + 33'(cin);
            ps  = i32.Sum;
            pc  = i32.Cout;
            lat = -1;
            @(negedge clk);
            i32.A     = a;
            i32.B     = b;
            i32.Cin   = cin;
            i32.start = 1'b1;
            for (int n = 1; n <= 36; n++) begin
                @(negedge clk);
                i32.start = 1'b0;
                if (i32.done) begin
                    lat = n;
                    break;
                end
                if (i32.Sum !== ps || i32.Cout !== pc) hold_bad = 1'b1;
            end
            checks++;
            if ({i32.Cout, i32.Sum} !== exp || lat !== 33) begin
                errors++;
                $display("FAIL rand32_%0d %h+%h+%b got %h lat=%0d want %h lat=33",
                         k, a, b, cin, {i32.Cout, i32.Sum}, lat, exp);
            end
        end
        checks++;
        if (hold_bad !== 1'b0) begin
            errors++;
            $display("FAIL rand32_hold got unstable=%b want 0", hold_bad);
        end
    endtask

    initial begin
        i8.start  = 1'b0;
        i8.A      = '0;
        i8.B      = '0;
        i8.Cin    = 1'b0;
        i1.start  = 1'b0;
        i1.A      = '0;
        i1.B      = '0;
        i1.Cin    = 1'b0;
        i32.start = 1'b0;
        i32.A     = '0;
        i32.B     = '0;
        i32.Cin   = 1'b0;
        test_reset();
        test_zero();
        test_carry();
        test_busy_guard();
        test_back_to_back();
        test_reset_midop();
        test_width1();
        test_random8();
        test_random32();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder built around the team's half-adder cell: two half adders plus an OR form the full-adder slice, with a registered carry.
- Sits directly downstream of the half-adder stage. It consumes the slice's Sum/Carry one bit per clock, LSB first, and produces a complete WIDTH-bit sum and carry-out.
- Trades WIDTH cycles of latency for a single adder slice, for area-constrained datapaths.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..32.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, do not override.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin an addition; sampled on the rising edge.
- A  input  WIDTH  operand A; captured on accepted start.
- B  input  WIDTH  operand B; captured on accepted start.
- Cin  input  1  carry-in; captured on accepted start.
- busy  output  1  high while the serial addition is in progress.
- done  output  1  one-cycle pulse; Sum/Cout are valid from this cycle.
- Sum  output  WIDTH  result; holds the last completed result.
- Cout  output  1  carry-out of the last completed result.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; busy=0; done=0; Sum=0; Cout=0; internal shift registers, carry register and counter cleared. Reset has priority over start and over an in-flight operation; a partial result is discarded and Sum/Cout are not updated.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 -> capture A, B, Cin into sa, sb, carry; cnt=0; go to RUN.
  - RUN: each cycle, the slice computes s = sa[0]^sb[0]^carry and c = majority(sa[0], sb[0], carry), using half-adder decomposition.
    - s shifts into the MSB of the internal sum register.
    - sa and sb shift right by 1; carry <= c; cnt <= cnt+1.
    - When cnt == WIDTH-1, that cycle's bit is the last: go to DONE and load Sum <= final sum register and Cout <= c.
  - DONE: done=1 for exactly this cycle, busy=0.
    - start=1 here is accepted: operands are captured and the FSM goes to RUN (back-to-back).
    - Otherwise the FSM returns to IDLE.
- busy is 1 exactly in RUN, i.e. WIDTH cycles per operation.
- Latency: start sampled at edge k -> done high in the cycle after edge k+WIDTH. Throughput is one result per WIDTH+1 cycles.
- start while busy=1 is ignored, and inputs are not re-sampled. A/B/Cin may change freely after the accepting edge.
- Sum/Cout change only on entry to DONE (or on reset) and otherwise hold.
- Arithmetic: {Cout, Sum} = A + B + Cin, modulo 2^(WIDTH+1). There is no overflow flag; Cout is the only indication.
- WIDTH=1: a single RUN cycle; the block degenerates to a registered full adder.
- Registered outputs only; no combinational path from inputs to outputs.

Test Plan:
- Reset, then start with A=0x00, B=0x00, Cin=0 (WIDTH=8):
  - busy high for 8 cycles;
  - done pulses once at cycle 9 after start;
  - Sum=0x00, Cout=0.
- Carry ripple, all with WIDTH=8:
  - A=0xFF, B=0x01, Cin=0 -> Sum=0x00, Cout=1.
  - A=0xA5, B=0x5A, Cin=1 -> Sum=0x00, Cout=1.
  - A=0x3C, B=0x42, Cin=0 -> Sum=0x7E, Cout=0.
- Busy guard:
  - Pulse start again at cycle 3 of RUN with A=0x11, B=0x11 -> ignored; the first result completes unchanged and no second done follows.
  - Pulse start in the DONE cycle -> the second operation runs back-to-back, and its done arrives WIDTH+1 cycles later.
- Reset mid-op:
  - Start A=0x0F, B=0x01 after a prior result of 0x7E.
  - Assert rst at RUN cycle 4 -> busy=0, done never pulses, Sum=0x00, Cout=0.
  - A fresh start then completes normally with Sum=0x10.
- WIDTH=1 instance, exhaustive over all 8 {A,B,Cin}: Sum/Cout match the full-adder truth table (for example 1+1+1 -> Sum=1, Cout=1), with done 2 cycles after each start.
- Random regression, WIDTH=8 and WIDTH=32: 1000 random operand sets, compared against a behavioural A+B+Cin model. Also check that Sum/Cout hold steady between done pulses.
